// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-stage branch redirect, wrong-path flush and control-flow counters
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ex_valid,
    input  logic            i_is_cf,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_pc_branch,
    input  logic            i_fetch_ready,
    input  logic            i_cnt_clear,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush_if,
    output logic            o_flush_id,
    output logic            o_stall_ex,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_misaligned_pc,
    output logic            o_busy,
    output logic [CNT_W-1:0] o_cnt_cf,
    output logic [CNT_W-1:0] o_cnt_taken
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        drain_q, drain_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              mis_q, mis_d;
    logic [XLEN-1:0]   mis_pc_q, mis_pc_d;
    logic [CNT_W-1:0]  cnt_cf_q, cnt_cf_d;
    logic [CNT_W-1:0]  cnt_taken_q, cnt_taken_d;

    logic qual_cf;
    logic accept;
    logic aligned;

    // Inputs only matter in IDLE; everything else is driven from state.
    assign qual_cf = (state_q == ST_IDLE) && i_ex_valid && i_is_cf;
    assign accept  = qual_cf && i_branch_taken;
    assign aligned = (i_pc_branch[1:0] == 2'b00);

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        redirect_pc_d = redirect_pc_q;
        mis_d         = 1'b0;
        mis_pc_d      = mis_pc_q;
        cnt_cf_d      = cnt_cf_q;
        cnt_taken_d   = cnt_taken_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (aligned) begin
                        state_d       = ST_REDIRECT;
                        redirect_pc_d = i_pc_branch;
                    end else begin
                        mis_d    = 1'b1;
                        mis_pc_d = i_pc_branch;
                    end
                end
            end
            ST_REDIRECT: begin
                if (i_fetch_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (qual_cf) begin
            cnt_cf_d = cnt_cf_q + 1'b1;
        end
        if (accept && aligned) begin
            cnt_taken_d = cnt_taken_q + 1'b1;
        end
        if (i_cnt_clear) begin
            cnt_cf_d    = '0;
            cnt_taken_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            drain_q       <= 4'd0;
            redirect_pc_q <= '0;
            mis_q         <= 1'b0;
            mis_pc_q      <= '0;
            cnt_cf_q      <= '0;
            cnt_taken_q   <= '0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            redirect_pc_q <= redirect_pc_d;
            mis_q         <= mis_d;
            mis_pc_q      <= mis_pc_d;
            cnt_cf_q      <= cnt_cf_d;
            cnt_taken_q   <= cnt_taken_d;
        end
    end

    assign o_redirect_valid = (state_q == ST_REDIRECT);
    assign o_stall_ex       = (state_q == ST_REDIRECT);
    assign o_flush_if       = (state_q != ST_IDLE);
    assign o_flush_id       = (state_q != ST_IDLE);
    assign o_busy           = (state_q != ST_IDLE);
    assign o_redirect_pc    = redirect_pc_q;
    assign o_misaligned     = mis_q;
    assign o_misaligned_pc  = mis_pc_q;
    assign o_cnt_cf         = cnt_cf_q;
    assign o_cnt_taken      = cnt_taken_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - self-checking bench for branch_redirect_ctrl (FLUSH_CYCLES 2 and 0)
module tb_branch_redirect_ctrl;

    localparam int CW  = 4;
    localparam int MOD = 1 << CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v, c, t, rdy, clr;
    logic [31:0] p;

    logic [1:0]         rv, fif, fid, st, mis, busy;
    logic [1:0][31:0]   rpc, mpc;
    logic [1:0][CW-1:0] ccf, ctk;

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(CW)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_ex_valid(v), .i_is_cf(c), .i_branch_taken(t),
        .i_pc_branch(p), .i_fetch_ready(rdy), .i_cnt_clear(clr),
        .o_redirect_valid(rv[0]), .o_redirect_pc(rpc[0]), .o_flush_if(fif[0]), .o_flush_id(fid[0]),
        .o_stall_ex(st[0]), .o_misaligned(mis[0]), .o_misaligned_pc(mpc[0]), .o_busy(busy[0]),
        .o_cnt_cf(ccf[0]), .o_cnt_taken(ctk[0]));

    branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(CW)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_ex_valid(v), .i_is_cf(c), .i_branch_taken(t),
        .i_pc_branch(p), .i_fetch_ready(rdy), .i_cnt_clear(clr),
        .o_redirect_valid(rv[1]), .o_redirect_pc(rpc[1]), .o_flush_if(fif[1]), .o_flush_id(fid[1]),
        .o_stall_ex(st[1]), .o_misaligned(mis[1]), .o_misaligned_pc(mpc[1]), .o_busy(busy[1]),
        .o_cnt_cf(ccf[1]), .o_cnt_taken(ctk[1]));

    int checks = 0;
    int errors = 0;

    // Reference: a pending-redirect flag plus a count of drain cycles still owed.
    int          fc[2] = '{2, 0};
    int          m_red[2], m_drain[2], m_mis[2], m_cf[2], m_tk[2];
    logic [31:0] m_pc[2], m_mpc[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_red[d] = 0; m_drain[d] = 0; m_mis[d] = 0; m_cf[d] = 0; m_tk[d] = 0;
                m_pc[d] = '0; m_mpc[d] = '0;
            end else begin
                m_mis[d] = 0;
                if (m_red[d] == 0 && m_drain[d] == 0) begin
                    if (v && c) begin
                        m_cf[d] = (m_cf[d] + 1) % MOD;
                        if (t) begin
                            if (p[1:0] == 2'b00) begin
                                m_red[d] = 1; m_pc[d] = p; m_tk[d] = (m_tk[d] + 1) % MOD;
                            end else begin
                                m_mis[d] = 1; m_mpc[d] = p;
                            end
                        end
                    end
                end else if (m_red[d] != 0) begin
                    if (rdy) begin
                        m_red[d] = 0; m_drain[d] = fc[d];
                    end
                end else begin
                    m_drain[d] = m_drain[d] - 1;
                end
                if (clr) begin
                    m_cf[d] = 0; m_tk[d] = 0;
                end
            end
        end
    endtask

    task automatic compare_model();
        for (int d = 0; d < 2; d++) begin
            logic fl;
            fl = (m_red[d] != 0) || (m_drain[d] > 0);
            chk($sformatf("d%0d_redirect_valid", d), 64'(rv[d]), 64'(m_red[d] != 0));
            chk($sformatf("d%0d_stall_ex", d), 64'(st[d]), 64'(m_red[d] != 0));
            chk($sformatf("d%0d_flush_if", d), 64'(fif[d]), 64'(fl));
            chk($sformatf("d%0d_flush_id", d), 64'(fid[d]), 64'(fl));
            chk($sformatf("d%0d_busy", d), 64'(busy[d]), 64'(fl));
            chk($sformatf("d%0d_misaligned", d), 64'(mis[d]), 64'(m_mis[d] != 0));
            chk($sformatf("d%0d_cnt_cf", d), 64'(ccf[d]), 64'(m_cf[d]));
            chk($sformatf("d%0d_cnt_taken", d), 64'(ctk[d]), 64'(m_tk[d]));
            if (m_red[d] != 0) chk($sformatf("d%0d_redirect_pc", d), 64'(rpc[d]), 64'(m_pc[d]));
            if (m_mis[d] != 0) chk($sformatf("d%0d_misaligned_pc", d), 64'(mpc[d]), 64'(m_mpc[d]));
        end
    endtask

    task automatic cycle(input logic r_i, v_i, c_i, t_i, input logic [31:0] p_i, input logic rdy_i, clr_i);
        rst = r_i; v = v_i; c = c_i; t = t_i; p = p_i; rdy = rdy_i; clr = clr_i;
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle_cycle(input logic rdy_i);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, rdy_i, 1'b0);
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_zero_flags"}, 64'({rv[d], fif[d], fid[d], st[d], mis[d], busy[d]}), 64'd0);
        chk({tag, "_zero_rpc"}, 64'(rpc[d]), 64'd0);
        chk({tag, "_zero_mpc"}, 64'(mpc[d]), 64'd0);
        chk({tag, "_zero_cnts"}, 64'({ccf[d], ctk[d]}), 64'd0);
    endtask

    typedef struct {
        logic r, v, c, t;
        logic [31:0] p;
        logic rdy, clr;
        logic e_rv, e_busy, e_mis;
        logic [CW-1:0] e_cf, e_tk;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int hi_cnt;
        logic pc_ok;

        // r v c t  pc  rdy clr | rv busy mis cf tk   (observed on the FLUSH_CYCLES=2 instance)
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h102, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd1};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd1};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

        rst = 1'b1; v = 0; c = 0; t = 0; p = '0; rdy = 0; clr = 0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].t, tbl[i].p, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("vec%0d_rv", i), 64'(rv[0]), 64'(tbl[i].e_rv));
            chk($sformatf("vec%0d_busy", i), 64'(busy[0]), 64'(tbl[i].e_busy));
            chk($sformatf("vec%0d_mis", i), 64'(mis[0]), 64'(tbl[i].e_mis));
            chk($sformatf("vec%0d_cnt_cf", i), 64'(ccf[0]), 64'(tbl[i].e_cf));
            chk($sformatf("vec%0d_cnt_taken", i), 64'(ctk[0]), 64'(tbl[i].e_tk));
            if (i == 1) chk("vec1_pc", 64'(rpc[0]), 64'h100);
            if (i == 5) chk("vec5_mis_pc", 64'(mpc[0]), 64'h102);
            if (i == 0) chk_zero(0, "vec0");
        end

        // Backpressured redirect: stays up 6 cycles, pc stable, EX pulses ignored.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_4440, 1'b0, 1'b0);
        hi_cnt = (rv[0] && st[0]) ? 1 : 0;
        pc_ok  = (rpc[0] == 32'h0000_4440);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_8880 + 32'(i * 4), 1'b0, 1'b0);
            if (rv[0] && st[0]) hi_cnt++;
            if (rpc[0] != 32'h0000_4440) pc_ok = 1'b0;
        end
        idle_cycle(1'b1);
        chk("bp_high_cycles", 64'(hi_cnt), 64'd6);
        chk("bp_pc_stable", 64'(pc_ok), 64'd1);
        chk("bp_drain_rv", 64'(rv[0]), 64'd0);
        chk("bp_cnt_cf", 64'(ccf[0]), 64'd1);
        chk("bp_fc0_idle", 64'(busy[1]), 64'd0);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Reset mid-REDIRECT, then mid-DRAIN.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0A00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0B00, 1'b1, 1'b1);
        chk_zero(0, "rst_redir");
        chk_zero(1, "rst_redir_fc0");
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0C00, 1'b1, 1'b0);
        idle_cycle(1'b1);
        chk("rst_drain_pre_busy", 64'(busy[0]), 64'd1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk_zero(0, "rst_drain");

        // Counter wrap and clear priority.
        for (int i = 0; i < MOD - 1; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0);
        chk("wrap_pre", 64'(ccf[0]), 64'(MOD - 1));
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0);
        chk("wrap_cf", 64'(ccf[0]), 64'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 1'b1);
        chk("clr_prio_cf", 64'(ccf[0]), 64'd0);
        chk("clr_prio_tk", 64'(ctk[0]), 64'd0);
        chk("clr_keeps_fsm", 64'(rv[0]), 64'd1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = $urandom;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, rp, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
